// File: rtl/rescue_pkg.sv
// Shared constants and state encoding for the Rescue-Prime input stages.
// The modulus is the BN254 scalar field prime.
package rescue_pkg;

    localparam int N_BITS      = 254;
    localparam int STATE_SIZE  = 3;
    localparam int RATE        = STATE_SIZE - 1;
    localparam int NUM_LANES   = 13;
    localparam int BATCH_WORDS = NUM_LANES * STATE_SIZE;

    localparam logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    localparam logic [3:0] LAST_LANE = 4'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        RST,
        LOAD,
        PAD,
        CAP,
        FIRE,
        WAIT_ACK
    } loader_state_t;

endpackage

// File: rtl/rescue_lane_loader_if.sv
// Element stream into the lane loader: valid/ready plus end-of-lane marker.
interface rescue_lane_loader_if;

    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [rescue_pkg::N_BITS-1:0] in_data;

    modport master (
        output in_valid,
        output in_last,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/rescue_canon_check.sv
// Flags whether a field element is already reduced below the modulus.
module rescue_canon_check
    import rescue_pkg::*;
(
    input  logic [N_BITS-1:0] data,
    output logic              is_canon
);

    assign is_canon = (data < PRIME_MODULUS);

endmodule

// File: rtl/rescue_lane_loader.sv
// Pads per-lane messages to the rate, appends a length word and streams
// the 39-word state into the permutation core, then fires and rewinds it.
module rescue_lane_loader
    import rescue_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    rescue_lane_loader_if.slave  in_if,
    output logic                 core_reset,
    output logic                 core_wr,
    output logic [N_BITS-1:0]    core_data,
    output logic                 core_enable,
    input  logic                 core_done,
    input  logic                 batch_ack,
    output logic                 busy,
    output logic                 err_framing,
    output logic                 err_noncanon
);

    loader_state_t state;
    loader_state_t nxt;

    logic [3:0] lane_cnt;
    logic [1:0] elem_cnt;
    logic       canon;
    logic       accept;

    rescue_canon_check u_canon (
        .data     (in_if.in_data),
        .is_canon (canon)
    );

    assign in_if.in_ready = (state == LOAD);
    assign busy           = (state != LOAD);
    assign accept         = in_if.in_valid && (state == LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            RST:  nxt = LOAD;
            LOAD: begin
                if (accept) begin
                    if (elem_cnt != 2'd0) begin
                        nxt = CAP;
                    end else if (in_if.in_last) begin
                        nxt = PAD;
                    end
                end
            end
            PAD:  nxt = CAP;
            CAP:  nxt = (lane_cnt == LAST_LANE) ? FIRE : LOAD;
            FIRE: begin
                if (core_done) begin
                    nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (batch_ack) begin
                    nxt = RST;
                end
            end
            default: nxt = RST;
        endcase
    end

    // Enable drops in the same edge that sees core_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset   <= 1'b1;
            core_wr      <= 1'b0;
            core_data    <= '0;
            core_enable  <= 1'b0;
            err_framing  <= 1'b0;
            err_noncanon <= 1'b0;
            lane_cnt     <= '0;
            elem_cnt     <= '0;
        end else begin
            core_reset  <= (nxt == RST);
            core_enable <= (state == FIRE) && (nxt == FIRE);
            core_wr     <= 1'b0;
            unique case (state)
                RST: begin
                    lane_cnt <= '0;
                    elem_cnt <= '0;
                end
                LOAD: begin
                    if (accept) begin
                        core_wr   <= 1'b1;
                        core_data <= canon ? in_if.in_data : '0;
                        elem_cnt  <= elem_cnt + 2'd1;
                        if (!canon) begin
                            err_noncanon <= 1'b1;
                        end
                        if (elem_cnt != 2'd0 && !in_if.in_last) begin
                            err_framing <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    core_wr   <= 1'b1;
                    core_data <= '0;
                end
                CAP: begin
                    core_wr   <= 1'b1;
                    core_data <= N_BITS'(elem_cnt);
                    elem_cnt  <= '0;
                    lane_cnt  <= (lane_cnt == LAST_LANE) ?
                                 4'd0 : lane_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rescue_lane_loader.sv
// Directed lane tables for the Rescue-Prime lane loader.
// Covers full, short, error, mid-batch reset and gapped batches.
module tb_rescue_lane_loader;

    localparam logic [253:0] P =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef struct {
        int           n;
        logic [253:0] d0;
        logic [253:0] d1;
        logic         l1;
        logic [253:0] e0;
        logic [253:0] e1;
        logic [253:0] e2;
    } lane_t;

    lane_t lanes [13];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         core_reset;
    logic         core_wr;
    logic [253:0] core_data;
    logic         core_enable;
    logic         core_done = 1'b0;
    logic         batch_ack = 1'b0;
    logic         busy;
    logic         err_framing;
    logic         err_noncanon;

    rescue_lane_loader_if bus ();

    rescue_lane_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (bus),
        .core_reset   (core_reset),
        .core_wr      (core_wr),
        .core_data    (core_data),
        .core_enable  (core_enable),
        .core_done    (core_done),
        .batch_ack    (batch_ack),
        .busy         (busy),
        .err_framing  (err_framing),
        .err_noncanon (err_noncanon)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [253:0] wr_data [$];
    int           wr_cyc  [$];
    int           en_rise = -1;
    logic         prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (core_wr) begin
            wr_data.push_back(core_data);
            wr_cyc.push_back(cyc);
        end
        if (core_enable && !prev_en) en_rise = cyc;
        prev_en = core_enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [253:0] act,
                       input logic [253:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " in_ready"}, 254'(bus.in_ready), 254'd0);
        chk({tag, " core_reset"}, 254'(core_reset), 254'd1);
        chk({tag, " core_wr"}, 254'(core_wr), 254'd0);
        chk({tag, " core_data"}, core_data, 254'd0);
        chk({tag, " core_enable"}, 254'(core_enable), 254'd0);
        chk({tag, " busy"}, 254'(busy), 254'd1);
        chk({tag, " err_framing"}, 254'(err_framing), 254'd0);
        chk({tag, " err_noncanon"}, 254'(err_noncanon), 254'd0);
    endtask

    task automatic send(input logic [253:0] d, input logic l, input bit rnd);
        int g;
        bit acc;
        if (rnd && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 254'($urandom);
            g = $urandom_range(1, 3);
            for (int k = 0; k < g; k++) begin
                core_done = 1'($urandom_range(0, 1));
                batch_ack = 1'($urandom_range(0, 1));
                tick();
            end
            core_done = 1'b0;
            batch_ack = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        g = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            g++;
        end while (!acc && g < 50);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake: got timeout want accept");
        end
    endtask

    task automatic drive_lanes(input int cnt, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            if (lanes[i].n == 1) begin
                send(lanes[i].d0, 1'b1, rnd);
            end else begin
                send(lanes[i].d0, 1'b0, rnd);
                send(lanes[i].d1, lanes[i].l1, rnd);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_words(input int base, input int cnt,
                               input string tag);
        logic [253:0] act;
        logic [253:0] exp;
        for (int k = 0; k < cnt; k++) begin
            act = (base + k < wr_data.size()) ? wr_data[base + k] : 'x;
            case (k % 3)
                0:       exp = lanes[k / 3].e0;
                1:       exp = lanes[k / 3].e1;
                default: exp = lanes[k / 3].e2;
            endcase
            chk($sformatf("%s word%0d", tag, k), act, exp);
        end
    endtask

    task automatic run_batch(input string tag, input bit rnd,
                             input logic ef, input logic en);
        int base;
        int g;
        base = wr_data.size();
        g = 0;
        drive_lanes(13, rnd);
        while (!core_enable && g < 20) begin
            tick();
            g++;
        end
        tick();
        tick();
        chk({tag, " count"}, 254'(wr_data.size() - base), 254'd39);
        check_words(base, 39, tag);
        if (wr_data.size() >= base + 39) begin
            chk({tag, " enable_rise"}, 254'(en_rise),
                254'(wr_cyc[base + 38] + 1));
            if (!rnd) begin
                chk({tag, " contiguous"},
                    254'(wr_cyc[base + 38] - wr_cyc[base]), 254'd38);
            end
        end
        chk({tag, " fire_enable"}, 254'(core_enable), 254'd1);
        chk({tag, " fire_busy"}, 254'(busy), 254'd1);
        chk({tag, " err_framing"}, 254'(err_framing), 254'(ef));
        chk({tag, " err_noncanon"}, 254'(err_noncanon), 254'(en));
        batch_ack = 1'b1;
        tick();
        batch_ack = 1'b0;
        tick();
        chk({tag, " ack_in_fire"}, 254'(core_enable), 254'd1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk({tag, " wait_enable"}, 254'(core_enable), 254'd0);
        chk({tag, " wait_ready"}, 254'(bus.in_ready), 254'd0);
        tick();
        tick();
        chk({tag, " wait_no_rewind"}, 254'(core_reset), 254'd0);
        batch_ack = 1'b1;
        tick();
        batch_ack = 1'b0;
        chk({tag, " rewind"}, 254'(core_reset), 254'd1);
        chk({tag, " rewind_ready"}, 254'(bus.in_ready), 254'd0);
        tick();
        chk({tag, " rewind_end"}, 254'(core_reset), 254'd0);
        chk({tag, " reload_ready"}, 254'(bus.in_ready), 254'd1);
        chk({tag, " sticky_framing"}, 254'(err_framing), 254'(ef));
        chk({tag, " sticky_noncanon"}, 254'(err_noncanon), 254'(en));
    endtask

    task automatic fill_full();
        for (int i = 0; i < 13; i++) begin
            lanes[i] = '{n: 2, d0: 254'(2 * i + 1), d1: 254'(2 * i + 2),
                         l1: 1'b1, e0: 254'(2 * i + 1),
                         e1: 254'(2 * i + 2), e2: 254'd2};
        end
    endtask

    task automatic fill_short();
        for (int i = 0; i < 13; i++) begin
            lanes[i] = '{n: 1, d0: 254'd7, d1: 254'd0, l1: 1'b1,
                         e0: 254'd7, e1: 254'd0, e2: 254'd1};
        end
    endtask

    task automatic fill_err();
        fill_short();
        lanes[0] = '{n: 2, d0: 254'd5, d1: 254'd6, l1: 1'b0,
                     e0: 254'd5, e1: 254'd6, e2: 254'd2};
        lanes[1] = '{n: 2, d0: P, d1: P - 254'd1, l1: 1'b1,
                     e0: 254'd0, e1: P - 254'd1, e2: 254'd2};
    endtask

    initial begin
        int base;
        int g;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        check_reset_vals("por");
        reset = 1'b0;
        tick();
        chk("load ready", 254'(bus.in_ready), 254'd1);
        chk("load busy", 254'(busy), 254'd0);
        chk("load core_reset", 254'(core_reset), 254'd0);

        core_done = 1'b1;
        batch_ack = 1'b1;
        tick();
        core_done = 1'b0;
        batch_ack = 1'b0;
        tick();
        chk("spurious ready", 254'(bus.in_ready), 254'd1);
        chk("spurious enable", 254'(core_enable), 254'd0);
        chk("spurious rewind", 254'(core_reset), 254'd0);
        chk("spurious writes", 254'(wr_data.size()), 254'd0);

        fill_full();
        run_batch("full", 1'b0, 1'b0, 1'b0);
        fill_short();
        run_batch("short", 1'b0, 1'b0, 1'b0);
        fill_err();
        run_batch("err", 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        check_reset_vals("err_clear");
        reset = 1'b0;
        tick();

        fill_full();
        base = wr_data.size();
        drive_lanes(6, 1'b0);
        g = 0;
        while (wr_data.size() - base < 18 && g < 10) begin
            tick();
            g++;
        end
        tick();
        chk("mid count", 254'(wr_data.size() - base), 254'd18);
        check_words(base, 18, "mid");
        reset = 1'b1;
        tick();
        check_reset_vals("mid_reset");
        reset = 1'b0;
        tick();
        run_batch("post", 1'b0, 1'b0, 1'b0);

        run_batch("gapped", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
